// File: rtl/m_axis_rc_adapt_x8.sv
// UltraScale+ RC completion beats -> legacy 3-DW-header completion TLP stream.
// Two-entry input skid FIFO, registered output stage, descriptor remap and dword-count check.
module m_axis_rc_adapt_x8 #(
    parameter int DATA_WIDTH = 256,
    parameter int KEEP_WIDTH = DATA_WIDTH/8
) (
    input  logic                  user_clk,
    input  logic                  user_reset_n,
    input  logic [DATA_WIDTH-1:0] m_axis_rc_tdata,
    input  logic [7:0]            m_axis_rc_tkeep,
    input  logic                  m_axis_rc_tlast,
    input  logic [74:0]           m_axis_rc_tuser,
    input  logic                  m_axis_rc_tvalid,
    output logic                  m_axis_rc_tready,
    output logic [DATA_WIDTH-1:0] m_axis_rc_tdata_a,
    output logic [KEEP_WIDTH-1:0] m_axis_rc_tkeep_a,
    output logic                  m_axis_rc_tlast_a,
    output logic [3:0]            m_axis_rc_tuser_a,
    output logic                  m_axis_rc_tvalid_a,
    input  logic                  m_axis_rc_tready_a,
    output logic                  rc_len_err,
    output logic [15:0]           rc_err_cnt
);

    // state    | meaning
    // ST_FIRST | next popped beat carries the RC descriptor
    // ST_BODY  | next popped beat is payload of the current packet
    typedef enum logic {ST_FIRST, ST_BODY} state_t;

    state_t state_q, state_d;

    logic [DATA_WIDTH-1:0] fifo_data [2];
    logic [7:0]            fifo_keep [2];
    logic [1:0]            fifo_last;
    logic [1:0]            fifo_disc;
    logic                  wr_ptr, rd_ptr;
    logic [1:0]            occ, occ_next;
    logic                  push, pop;

    logic [DATA_WIDTH-1:0] h_data;
    logic [95:0]           desc;
    logic [7:0]            h_keep;
    logic                  h_last, h_disc, is_first;
    logic [10:0]           dwc, rem_q, rem_d, rem_cur, cap;
    logic                  err_seen_q, err_seen_d, mismatch, len_err_d;
    logic                  ep_q, ep_d, rcmp_q, rcmp_d;
    logic [31:0]           dw0, dw1, dw2;
    logic [DATA_WIDTH-1:0] data_d;
    logic [KEEP_WIDTH-1:0] keep_d;
    logic [3:0]            user_d;
    logic                  tuser_unused;

    assign tuser_unused = &{1'b0, m_axis_rc_tuser[74:43], m_axis_rc_tuser[41:0]};

    assign push = m_axis_rc_tvalid && m_axis_rc_tready;
    assign pop  = (occ != 2'd0) && (!m_axis_rc_tvalid_a || m_axis_rc_tready_a);

    always_comb begin
        occ_next = occ;
        if (push && !pop)
            occ_next = occ + 2'd1;
        else if (pop && !push)
            occ_next = occ - 2'd1;
    end

    always_ff @(posedge user_clk) begin
        if (push) begin
            fifo_data[wr_ptr] <= m_axis_rc_tdata;
            fifo_keep[wr_ptr] <= m_axis_rc_tkeep;
        end
    end

    always_ff @(posedge user_clk or negedge user_reset_n) begin
        if (!user_reset_n) begin
            wr_ptr           <= 1'b0;
            rd_ptr           <= 1'b0;
            occ              <= 2'd0;
            fifo_last        <= 2'b00;
            fifo_disc        <= 2'b00;
            m_axis_rc_tready <= 1'b0;
        end else begin
            if (push) begin
                fifo_last[wr_ptr] <= m_axis_rc_tlast;
                fifo_disc[wr_ptr] <= m_axis_rc_tuser[42];
                wr_ptr            <= ~wr_ptr;
            end
            if (pop)
                rd_ptr <= ~rd_ptr;
            occ              <= occ_next;
            m_axis_rc_tready <= (occ_next < 2'd2);
        end
    end

    assign h_data   = fifo_data[rd_ptr];
    assign h_keep   = fifo_keep[rd_ptr];
    assign h_last   = fifo_last[rd_ptr];
    assign h_disc   = fifo_disc[rd_ptr];
    assign desc     = h_data[95:0];
    assign is_first = (state_q == ST_FIRST);
    assign dwc      = desc[42:32];

    // A 1024-dword completion encodes its length field as 0 by truncation.
    assign dw0 = {(dwc != 11'd0) ? 3'b010 : 3'b000, desc[29] ? 5'b01011 : 5'b01010,
                  1'b0, desc[91:89], 4'b0000, 1'b0, desc[46], desc[93:92], 2'b00, dwc[9:0]};
    assign dw1 = {desc[87:72], desc[45:43], 1'b0, desc[27:16]};
    assign dw2 = {desc[63:48], desc[71:64], 1'b0, desc[6:0]};

    always_comb begin
        state_d    = state_q;
        rem_d      = rem_q;
        err_seen_d = err_seen_q;
        ep_d       = ep_q;
        rcmp_d     = rcmp_q;
        len_err_d  = 1'b0;
        rem_cur    = is_first ? dwc : rem_q;
        cap        = is_first ? 11'd5 : 11'd8;
        mismatch   = h_last ? (rem_cur > cap) : (rem_cur <= cap);
        data_d     = is_first ? {h_data[DATA_WIDTH-1:96], dw2, dw1, dw0} : h_data;
        user_d     = {is_first, is_first ? desc[30] : rcmp_q, is_first ? desc[46] : ep_q, h_disc};
        keep_d     = '0;
        for (int i = 0; i < 8; i++)
            keep_d[4*i +: 4] = {4{h_keep[i]}};
        if (pop) begin
            // Only the first mismatch of a packet is reported.
            len_err_d  = mismatch && !(err_seen_q && !is_first);
            err_seen_d = !h_last && (len_err_d || (err_seen_q && !is_first));
            rem_d      = (rem_cur > cap) ? rem_cur - cap : 11'd0;
            state_d    = h_last ? ST_FIRST : ST_BODY;
            if (is_first) begin
                ep_d   = desc[46];
                rcmp_d = desc[30];
            end
        end
    end

    always_ff @(posedge user_clk or negedge user_reset_n) begin
        if (!user_reset_n) begin
            state_q            <= ST_FIRST;
            rem_q              <= 11'd0;
            err_seen_q         <= 1'b0;
            ep_q               <= 1'b0;
            rcmp_q             <= 1'b0;
            m_axis_rc_tvalid_a <= 1'b0;
            m_axis_rc_tdata_a  <= '0;
            m_axis_rc_tkeep_a  <= '0;
            m_axis_rc_tlast_a  <= 1'b0;
            m_axis_rc_tuser_a  <= 4'd0;
            rc_len_err         <= 1'b0;
            rc_err_cnt         <= 16'd0;
        end else begin
            state_q    <= state_d;
            rem_q      <= rem_d;
            err_seen_q <= err_seen_d;
            ep_q       <= ep_d;
            rcmp_q     <= rcmp_d;
            rc_len_err <= len_err_d;
            if (len_err_d && rc_err_cnt != 16'hFFFF)
                rc_err_cnt <= rc_err_cnt + 16'd1;
            if (pop) begin
                m_axis_rc_tvalid_a <= 1'b1;
                m_axis_rc_tdata_a  <= data_d;
                m_axis_rc_tkeep_a  <= keep_d;
                m_axis_rc_tlast_a  <= h_last;
                m_axis_rc_tuser_a  <= user_d;
            end else if (m_axis_rc_tready_a) begin
                m_axis_rc_tvalid_a <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_m_axis_rc_adapt_x8.sv
// Directed self-checking bench for m_axis_rc_adapt_x8.
`timescale 1ns/1ps
module tb_m_axis_rc_adapt_x8;

    logic         user_clk = 1'b0;
    logic         user_reset_n;
    logic [255:0] m_axis_rc_tdata;
    logic [7:0]   m_axis_rc_tkeep;
    logic         m_axis_rc_tlast;
    logic [74:0]  m_axis_rc_tuser;
    logic         m_axis_rc_tvalid;
    logic         m_axis_rc_tready;
    logic [255:0] m_axis_rc_tdata_a;
    logic [31:0]  m_axis_rc_tkeep_a;
    logic         m_axis_rc_tlast_a;
    logic [3:0]   m_axis_rc_tuser_a;
    logic         m_axis_rc_tvalid_a;
    logic         m_axis_rc_tready_a;
    logic         rc_len_err;
    logic [15:0]  rc_err_cnt;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [255:0] d;
        logic [31:0]  k;
        logic         l;
        logic [3:0]   u;
    } beat_t;

    beat_t outq[$];
    int    err_pulses = 0;

    localparam logic [159:0] PAY = 160'hDEAD_BEEF_0102_0304_0506_0708_090A_0B0C_0D0E_0F10;

    m_axis_rc_adapt_x8 dut (
        .user_clk           (user_clk),
        .user_reset_n       (user_reset_n),
        .m_axis_rc_tdata    (m_axis_rc_tdata),
        .m_axis_rc_tkeep    (m_axis_rc_tkeep),
        .m_axis_rc_tlast    (m_axis_rc_tlast),
        .m_axis_rc_tuser    (m_axis_rc_tuser),
        .m_axis_rc_tvalid   (m_axis_rc_tvalid),
        .m_axis_rc_tready   (m_axis_rc_tready),
        .m_axis_rc_tdata_a  (m_axis_rc_tdata_a),
        .m_axis_rc_tkeep_a  (m_axis_rc_tkeep_a),
        .m_axis_rc_tlast_a  (m_axis_rc_tlast_a),
        .m_axis_rc_tuser_a  (m_axis_rc_tuser_a),
        .m_axis_rc_tvalid_a (m_axis_rc_tvalid_a),
        .m_axis_rc_tready_a (m_axis_rc_tready_a),
        .rc_len_err         (rc_len_err),
        .rc_err_cnt         (rc_err_cnt)
    );

    always #5 user_clk = ~user_clk;

    // Output transfers are recorded at the falling edge; tready_a only changes just after a rising edge.
    always @(negedge user_clk) begin
        beat_t b;
        if (user_reset_n) begin
            if (m_axis_rc_tvalid_a && m_axis_rc_tready_a) begin
                b.d = m_axis_rc_tdata_a;
                b.k = m_axis_rc_tkeep_a;
                b.l = m_axis_rc_tlast_a;
                b.u = m_axis_rc_tuser_a;
                outq.push_back(b);
            end
            if (rc_len_err)
                err_pulses++;
        end
    end

    function automatic logic [95:0] mk_desc(input logic [10:0] dwc, input logic [11:0] bc,
                                            input logic [6:0] la, input logic [7:0] tag,
                                            input logic [15:0] req, input logic [15:0] cpl,
                                            input logic [2:0] status, input logic locked,
                                            input logic ep, input logic rcmp);
        logic [95:0] d;
        d = '0;
        d[42:32] = dwc;
        d[27:16] = bc;
        d[6:0]   = la;
        d[71:64] = tag;
        d[63:48] = req;
        d[87:72] = cpl;
        d[45:43] = status;
        d[29]    = locked;
        d[46]    = ep;
        d[30]    = rcmp;
        return d;
    endfunction

    // Called and returns 1 ns after a falling edge.
    task automatic push_beat(input logic [255:0] d, input logic [7:0] k, input logic l, input logic disc);
        int t = 0;
        m_axis_rc_tdata     = d;
        m_axis_rc_tkeep     = k;
        m_axis_rc_tlast     = l;
        m_axis_rc_tuser     = '0;
        m_axis_rc_tuser[42] = disc;
        m_axis_rc_tvalid    = 1'b1;
        while (!m_axis_rc_tready && t < 50) begin
            @(negedge user_clk); #1;
            t++;
        end
        checks++;
        if (!m_axis_rc_tready) begin
            errors++;
            $display("FAIL push_timeout: tready=%0b after %0d cycles, need 1", m_axis_rc_tready, t);
        end
        @(negedge user_clk); #1;
        m_axis_rc_tvalid = 1'b0;
    endtask

    task automatic wait_out(input int n, input string name);
        int t = 0;
        while (outq.size() < n && t < 200) begin
            @(negedge user_clk); #1;
            t++;
        end
        repeat (2) @(negedge user_clk);
        #1;
        checks++;
        if (outq.size() != n) begin
            errors++;
            $display("FAIL %s_beats: got %0d output beats, need %0d", name, outq.size(), n);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge user_clk);
        #1;
        checks++;
        if ({m_axis_rc_tready, m_axis_rc_tvalid_a, m_axis_rc_tlast_a, rc_len_err} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_ctrl: tready/tvalid_a/tlast_a/err=%b, need 0000",
                     {m_axis_rc_tready, m_axis_rc_tvalid_a, m_axis_rc_tlast_a, rc_len_err});
        end
        checks++;
        if (m_axis_rc_tdata_a !== '0 || m_axis_rc_tkeep_a !== '0 || m_axis_rc_tuser_a !== '0 || rc_err_cnt !== '0) begin
            errors++;
            $display("FAIL reset_data: keep_a=%h user_a=%h cnt=%h, need all 0",
                     m_axis_rc_tkeep_a, m_axis_rc_tuser_a, rc_err_cnt);
        end
        user_reset_n = 1'b1;
        checks++;
        if (m_axis_rc_tready !== 1'b0) begin
            errors++;
            $display("FAIL reset_release_tready: got %b, need 0", m_axis_rc_tready);
        end
        @(negedge user_clk); #1;
        checks++;
        if (m_axis_rc_tready !== 1'b1) begin
            errors++;
            $display("FAIL reset_tready_rise: got %b, need 1", m_axis_rc_tready);
        end
    endtask

    task automatic check_single(input string name, input logic [255:0] expd, input logic [31:0] expk, input int e0);
        if (outq.size() >= 1) begin
            checks++;
            if (outq[0].d[31:0] !== expd[31:0]) begin
                errors++;
                $display("FAIL %s_dw0: got %h, need %h", name, outq[0].d[31:0], expd[31:0]);
            end
            checks++;
            if (outq[0].d[63:32] !== expd[63:32]) begin
                errors++;
                $display("FAIL %s_dw1: got %h, need %h", name, outq[0].d[63:32], expd[63:32]);
            end
            checks++;
            if (outq[0].d[95:64] !== expd[95:64]) begin
                errors++;
                $display("FAIL %s_dw2: got %h, need %h", name, outq[0].d[95:64], expd[95:64]);
            end
            checks++;
            if (outq[0].d[255:96] !== expd[255:96]) begin
                errors++;
                $display("FAIL %s_payload: got %h, need %h", name, outq[0].d[255:96], expd[255:96]);
            end
            checks++;
            if (outq[0].k !== expk || outq[0].l !== 1'b1 || outq[0].u !== 4'b1000) begin
                errors++;
                $display("FAIL %s_side: keep=%h last=%b user=%b, need %h 1 1000",
                         name, outq[0].k, outq[0].l, outq[0].u, expk);
            end
        end
        checks++;
        if (err_pulses != e0) begin
            errors++;
            $display("FAIL %s_err: got %0d error pulses, need %0d", name, err_pulses, e0);
        end
    endtask

    task automatic test_single_cpld();
        logic [255:0] d;
        int e0;
        outq.delete();
        e0 = err_pulses;
        d = {PAY, mk_desc(11'd1, 12'd4, 7'h04, 8'h12, 16'h0100, 16'h0200, 3'b000, 1'b0, 1'b0, 1'b0)};
        push_beat(d, 8'h0F, 1'b1, 1'b0);
        checks++;
        if (m_axis_rc_tvalid_a !== 1'b0) begin
            errors++;
            $display("FAIL latency_early: tvalid_a=%b one cycle after accept, need 0", m_axis_rc_tvalid_a);
        end
        @(negedge user_clk); #1;
        checks++;
        if (m_axis_rc_tvalid_a !== 1'b1) begin
            errors++;
            $display("FAIL latency_n2: tvalid_a=%b two cycles after accept, need 1", m_axis_rc_tvalid_a);
        end
        wait_out(1, "single");
        check_single("single", {PAY, 32'h01001204, 32'h02000004, 32'h4A000001}, 32'h0000FFFF, e0);
    endtask

    task automatic test_multi_beat();
        logic [255:0] d [3];
        int e0;
        outq.delete();
        e0 = err_pulses;
        d[0] = {PAY, mk_desc(11'd14, 12'd56, 7'h00, 8'h21, 16'h0100, 16'h0200, 3'b000, 1'b0, 1'b0, 1'b1)};
        d[1] = {8{32'hB0B0_0001}};
        d[2] = {8{32'hB0B0_0002}};
        push_beat(d[0], 8'hFF, 1'b0, 1'b0);
        push_beat(d[1], 8'hFF, 1'b0, 1'b0);
        push_beat(d[2], 8'h01, 1'b1, 1'b0);
        wait_out(3, "multi");
        if (outq.size() >= 3) begin
            checks++;
            if (outq[0].d !== {PAY, 32'h01002100, 32'h02000038, 32'h4A00000E}) begin
                errors++;
                $display("FAIL multi_hdr: got %h, need header 4A00000E/02000038/01002100", outq[0].d[95:0]);
            end
            checks++;
            if (outq[1].d !== d[1] || outq[2].d !== d[2]) begin
                errors++;
                $display("FAIL multi_body: got %h / %h, need %h / %h", outq[1].d[31:0], outq[2].d[31:0], d[1][31:0], d[2][31:0]);
            end
            checks++;
            if ({outq[0].k, outq[1].k, outq[2].k} !== {32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0000000F}) begin
                errors++;
                $display("FAIL multi_keep: got %h %h %h, need FFFFFFFF FFFFFFFF 0000000F", outq[0].k, outq[1].k, outq[2].k);
            end
            checks++;
            if ({outq[0].l, outq[1].l, outq[2].l} !== 3'b001) begin
                errors++;
                $display("FAIL multi_last: got %b, need 001", {outq[0].l, outq[1].l, outq[2].l});
            end
            checks++;
            if ({outq[0].u, outq[1].u, outq[2].u} !== {4'b1100, 4'b0100, 4'b0100}) begin
                errors++;
                $display("FAIL multi_user: got %b %b %b, need 1100 0100 0100", outq[0].u, outq[1].u, outq[2].u);
            end
        end
        checks++;
        if (err_pulses != e0) begin
            errors++;
            $display("FAIL multi_err: got %0d error pulses, need %0d", err_pulses, e0);
        end
    endtask

    task automatic test_len_err();
        logic [255:0] d0, d1;
        int e0;
        outq.delete();
        e0 = err_pulses;
        d0 = {PAY, mk_desc(11'd14, 12'd56, 7'h00, 8'h22, 16'h0100, 16'h0200, 3'b000, 1'b0, 1'b0, 1'b0)};
        d1 = {8{32'hC0C0_0001}};
        push_beat(d0, 8'hFF, 1'b0, 1'b0);
        push_beat(d1, 8'hFF, 1'b1, 1'b0);
        wait_out(2, "early_last");
        checks++;
        if (err_pulses != e0 + 1 || rc_err_cnt !== 16'd1) begin
            errors++;
            $display("FAIL early_last_err: pulses=%0d cnt=%0d, need %0d and 1", err_pulses - e0, rc_err_cnt, 1);
        end
        if (outq.size() >= 2) begin
            checks++;
            if (outq[1].d !== d1 || outq[1].l !== 1'b1 || outq[0].l !== 1'b0) begin
                errors++;
                $display("FAIL early_last_fwd: body=%h lasts=%b%b, need %h 01", outq[1].d[31:0], outq[0].l, outq[1].l, d1[31:0]);
            end
        end

        outq.delete();
        e0 = err_pulses;
        push_beat({PAY, mk_desc(11'd1, 12'd4, 7'h04, 8'h12, 16'h0100, 16'h0200, 3'b000, 1'b0, 1'b0, 1'b0)}, 8'h0F, 1'b1, 1'b0);
        wait_out(1, "after_err");
        check_single("after_err", {PAY, 32'h01001204, 32'h02000004, 32'h4A000001}, 32'h0000FFFF, e0);

        outq.delete();
        e0 = err_pulses;
        push_beat({PAY, mk_desc(11'd0, 12'd8, 7'h00, 8'h13, 16'h0100, 16'h0200, 3'b000, 1'b0, 1'b0, 1'b0)}, 8'h07, 1'b0, 1'b0);
        push_beat({8{32'hC0C0_0002}}, 8'h01, 1'b1, 1'b0);
        wait_out(2, "dwc0_nolast");
        checks++;
        if (err_pulses != e0 + 1 || rc_err_cnt !== 16'd2) begin
            errors++;
            $display("FAIL dwc0_nolast_err: pulses=%0d cnt=%0d, need 1 and 2", err_pulses - e0, rc_err_cnt);
        end

        outq.delete();
        e0 = err_pulses;
        push_beat({PAY, mk_desc(11'd5, 12'd20, 7'h04, 8'h12, 16'h0100, 16'h0200, 3'b000, 1'b0, 1'b0, 1'b0)}, 8'hFF, 1'b1, 1'b0);
        wait_out(1, "dwc5");
        check_single("dwc5", {PAY, 32'h01001204, 32'h02000014, 32'h4A000005}, 32'hFFFFFFFF, e0);

        outq.delete();
        e0 = err_pulses;
        push_beat({PAY, mk_desc(11'd13, 12'd52, 7'h00, 8'h14, 16'h0100, 16'h0200, 3'b000, 1'b0, 1'b1, 1'b1)}, 8'hFF, 1'b0, 1'b0);
        push_beat({8{32'hC0C0_0003}}, 8'hFF, 1'b1, 1'b1);
        wait_out(2, "ep_disc");
        if (outq.size() >= 2) begin
            checks++;
            if (outq[0].d[31:0] !== 32'h4A00400D || outq[0].u !== 4'b1110 || outq[1].u !== 4'b0111) begin
                errors++;
                $display("FAIL ep_disc: dw0=%h users=%b %b, need 4A00400D 1110 0111", outq[0].d[31:0], outq[0].u, outq[1].u);
            end
        end
        checks++;
        if (err_pulses != e0 || rc_err_cnt !== 16'd2) begin
            errors++;
            $display("FAIL ep_disc_err: pulses=%0d cnt=%0d, need 0 and 2", err_pulses - e0, rc_err_cnt);
        end
    endtask

    task automatic test_locked();
        int e0;
        outq.delete();
        e0 = err_pulses;
        push_beat({PAY, mk_desc(11'd0, 12'd8, 7'h00, 8'h12, 16'h0100, 16'h0200, 3'b001, 1'b1, 1'b0, 1'b0)}, 8'h07, 1'b1, 1'b0);
        wait_out(1, "locked");
        check_single("locked", {PAY, 32'h01001200, 32'h02002008, 32'h0B000000}, 32'h00000FFF, e0);
    endtask

    task automatic test_back_to_back();
        logic [255:0] exp_d [9];
        logic         saw_low = 1'b0;
        logic         unstable = 1'b0;
        logic         have = 1'b0;
        logic [255:0] held = '0;
        int           e0;
        outq.delete();
        e0 = err_pulses;
        for (int p = 0; p < 3; p++) begin
            exp_d[3*p]   = {PAY, 16'h0100, 8'h30 + 8'(p), 8'h00, 32'h02000038, 32'h4A00000E};
            exp_d[3*p+1] = {8{24'hD0D0D0, 8'(16*p + 1)}};
            exp_d[3*p+2] = {8{24'hD0D0D0, 8'(16*p + 2)}};
        end
        fork
            begin
                for (int p = 0; p < 3; p++) begin
                    push_beat({PAY, mk_desc(11'd14, 12'd56, 7'h00, 8'h30 + 8'(p), 16'h0100, 16'h0200, 3'b000, 1'b0, 1'b0, 1'b0)},
                              8'hFF, 1'b0, 1'b0);
                    push_beat(exp_d[3*p+1], 8'hFF, 1'b0, 1'b0);
                    push_beat(exp_d[3*p+2], 8'h01, 1'b1, 1'b0);
                end
            end
            begin
                repeat (3) @(posedge user_clk);
                #1;
                m_axis_rc_tready_a = 1'b0;
                for (int c = 0; c < 10; c++) begin
                    @(negedge user_clk);
                    if (m_axis_rc_tready === 1'b0)
                        saw_low = 1'b1;
                    if (m_axis_rc_tvalid_a) begin
                        if (!have) begin
                            held = m_axis_rc_tdata_a;
                            have = 1'b1;
                        end else if (m_axis_rc_tdata_a !== held) begin
                            unstable = 1'b1;
                        end
                    end
                end
                @(posedge user_clk); #1;
                m_axis_rc_tready_a = 1'b1;
            end
        join
        wait_out(9, "b2b");
        checks++;
        if (saw_low !== 1'b1) begin
            errors++;
            $display("FAIL b2b_tready_drop: tready low seen=%b, need 1", saw_low);
        end
        checks++;
        if (unstable !== 1'b0 || have !== 1'b1) begin
            errors++;
            $display("FAIL b2b_stall_stable: unstable=%b valid_seen=%b, need 0 1", unstable, have);
        end
        for (int i = 0; i < 9; i++) begin
            if (i < outq.size()) begin
                checks++;
                if (outq[i].d !== exp_d[i] || outq[i].l !== (i % 3 == 2)) begin
                    errors++;
                    $display("FAIL b2b_beat%0d: data=%h last=%b, need %h %b",
                             i, outq[i].d[95:0], outq[i].l, exp_d[i][95:0], (i % 3 == 2));
                end
            end
        end
        checks++;
        if (err_pulses != e0) begin
            errors++;
            $display("FAIL b2b_err: got %0d error pulses, need 0", err_pulses - e0);
        end
    endtask

    task automatic test_reset_mid();
        int e0;
        push_beat({PAY, mk_desc(11'd14, 12'd56, 7'h00, 8'h40, 16'h0100, 16'h0200, 3'b000, 1'b0, 1'b0, 1'b0)}, 8'hFF, 1'b0, 1'b0);
        push_beat({8{32'hE0E0_0001}}, 8'hFF, 1'b0, 1'b0);
        @(negedge user_clk); #1;
        user_reset_n = 1'b0;
        #1;
        checks++;
        if ({m_axis_rc_tready, m_axis_rc_tvalid_a, m_axis_rc_tlast_a, rc_len_err} !== 4'b0000 || rc_err_cnt !== 16'd0) begin
            errors++;
            $display("FAIL midreset_ctrl: tready/tvalid_a/tlast_a/err=%b cnt=%0d, need 0000 0",
                     {m_axis_rc_tready, m_axis_rc_tvalid_a, m_axis_rc_tlast_a, rc_len_err}, rc_err_cnt);
        end
        checks++;
        if (m_axis_rc_tdata_a !== '0 || m_axis_rc_tkeep_a !== '0 || m_axis_rc_tuser_a !== '0) begin
            errors++;
            $display("FAIL midreset_data: keep_a=%h user_a=%h, need 0", m_axis_rc_tkeep_a, m_axis_rc_tuser_a);
        end
        repeat (2) @(negedge user_clk);
        #1;
        user_reset_n = 1'b1;
        @(negedge user_clk); #1;
        outq.delete();
        e0 = err_pulses;
        push_beat({PAY, mk_desc(11'd1, 12'd4, 7'h04, 8'h12, 16'h0100, 16'h0200, 3'b000, 1'b0, 1'b0, 1'b0)}, 8'h0F, 1'b1, 1'b0);
        wait_out(1, "midreset");
        check_single("midreset", {PAY, 32'h01001204, 32'h02000004, 32'h4A000001}, 32'h0000FFFF, e0);
    endtask

    initial begin
        user_reset_n       = 1'b0;
        m_axis_rc_tdata    = '0;
        m_axis_rc_tkeep    = '0;
        m_axis_rc_tlast    = 1'b0;
        m_axis_rc_tuser    = '0;
        m_axis_rc_tvalid   = 1'b0;
        m_axis_rc_tready_a = 1'b1;
        test_reset();
        test_single_cpld();
        test_multi_beat();
        test_len_err();
        test_locked();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/m_axis_rc_adapt_x8.md
# m_axis_rc_adapt_x8

Converts UltraScale+ requester-completion (RC) beats from the PCIe hard IP into the legacy 3-DW-header completion TLP stream consumed by the LitePCIe 256-bit datapath. It is the receive-side counterpart of the RQ adapter: requests leave through the RQ adapter, and the completions they generate return through this block. It remaps the 96-bit RC descriptor into a legacy completion header, expands dword keep to byte keep and checks the descriptor's dword count against tlast. Input skid buffering and a registered output give full throughput under backpressure.

## Interface
- DATA_WIDTH, 256, data width in bits; only 256 is supported.
- KEEP_WIDTH, DATA_WIDTH/8, legacy byte-keep width.
- user_clk  in  1  sole clock.
- user_reset_n  in  1  asynchronous, active-low reset.
- m_axis_rc_tdata  in  256  hard-IP RC data; descriptor in DW0-2 of the first beat.
- m_axis_rc_tkeep  in  8  dword keep.
- m_axis_rc_tlast  in  1  end of packet.
- m_axis_rc_tuser  in  75  RC sideband; bit 42 = discontinue.
- m_axis_rc_tvalid  in  1  beat valid.
- m_axis_rc_tready  out  1  registered; high when the skid buffer has at least one free entry.
- m_axis_rc_tdata_a  out  256  legacy TLP data.
- m_axis_rc_tkeep_a  out  32  byte keep.
- m_axis_rc_tlast_a  out  1  end of packet.
- m_axis_rc_tuser_a  out  4  [0] discontinue, [1] poisoned, [2] request completed, [3] start of packet.
- m_axis_rc_tvalid_a  out  1  beat valid.
- m_axis_rc_tready_a  in  1  downstream ready.
- rc_len_err  out  1  one-cycle pulse on a dword-count/tlast mismatch.
- rc_err_cnt  out  16  saturating count of mismatched packets.

## Operation
- Input stage: a 2-entry FIFO accepts a beat on tvalid&&tready.
  - tready = (occupancy<2), registered.
- Output stage: one register loads from the FIFO head when empty or when tvalid_a&&tready_a. Output holds stable while tvalid_a&&!tready_a.
- Packet state, tracked on FIFO pops:
  - FIRST: the popped beat is a header beat. Latch dwc = desc[42:32] (11 bits) and set rem = dwc.
  - BODY: entered after a non-tlast header beat.
  - Any tlast pop returns the state to FIRST.
- Header remap on FIRST beats; output DW3-7 carry input DW3-7 unchanged:
  - DW0: [31:29] = (dwc!=0) ? 3'b010 : 3'b000; [28:24] = desc[29] ? 5'b01011 : 5'b01010; [22:20] = desc[91:89]; [15] = 0; [14] = desc[46]; [13:12] = desc[93:92]; [9:0] = dwc[9:0] (1024 encodes as 0); all other bits 0.
  - DW1: [31:16] = desc[87:72]; [15:13] = desc[45:43]; [12] = 0; [11:0] = desc[27:16].
  - DW2: [31:16] = desc[63:48]; [15:8] = desc[71:64]; [7] = 0; [6:0] = desc[6:0].
- BODY beats pass tdata unchanged.
- Keep: tkeep_a[4i+3:4i] = {4{tkeep[i]}}.
- tuser_a:
  - [0] = tuser[42] on every beat.
  - [1] = desc[46] and [2] = desc[30], latched on the FIRST beat and held through the packet.
  - [3] = 1 only on FIRST beats.
- Length check:
  - Capacity is 5 dwords on the FIRST beat and 8 dwords on BODY beats.
  - After each pop, rem <= (rem>cap) ? rem-cap : 0.
  - Mismatch: tlast with rem>cap at the time of the pop, or a non-tlast pop with rem<=cap.
  - At most one error per packet; the mismatching packet is still forwarded intact.
- rc_err_cnt increments per error and saturates at 0xFFFF.

## Timing
- Reset values:
  - m_axis_rc_tready = 0; it rises one cycle after reset release.
  - tvalid_a, tlast_a, tuser_a, tkeep_a, tdata_a, rc_len_err = 0; rc_err_cnt = 0.
  - FIFO empty; state FIRST.
- Latency: an input beat accepted in cycle N appears on tvalid_a in cycle N+2 when there is no backpressure. Throughput is one beat per cycle.
- rc_len_err pulses for exactly one cycle: the first cycle the offending beat is presented on the output. It does not repeat while that beat is stalled.
- A FIFO push and pop in the same cycle leave occupancy unchanged.
- Reset mid-packet: asynchronous clear. The in-flight packet is discarded and the next accepted beat is a FIRST beat.
- dwc=0 completions (Cpl without data) are single-beat and have tkeep 0x07 from the IP. A tlast missing on such a beat is a mismatch.

## Test plan
- Single-beat CplD: dwc=1, byte count 4, lower address 0x04, tag 0x12, requester 0x0100, completer 0x0200, tkeep 0x0F, tlast.
  - Required: DW0=0x4A000001, DW1=0x02000004, DW2=0x01001204, tkeep_a=0x0000FFFF, tuser_a[3]=1, rc_len_err=0.
- dwc=14 sent as 3 beats with tkeep 0xFF, 0xFF, 0x01.
  - Required: 3 output beats with tkeep_a 0xFFFFFFFF, 0xFFFFFFFF, 0x0000000F; tlast_a only on beat 3; no error.
- Same dwc=14 packet with tlast on beat 2.
  - Required: rc_len_err pulses once; rc_err_cnt=1; beats forwarded.
  - A following dwc=1 packet is decoded as FIRST and produces no error.
- Locked Cpl without data: dwc=0, desc[29]=1, status 001, byte count 8.
  - Required: DW0=0x0B000000, DW1=completer<<16 | 0x2008.
- Backpressure: hold tready_a low 10 cycles during back-to-back 3-beat packets.
  - Required: tready drops once 2 entries are buffered; no beat lost, duplicated or reordered; output stable while stalled.
- Reset: drive user_reset_n low mid-packet.
  - Required: outputs reach reset values immediately.
  - After release, a new dwc=1 packet produces the DW0-2 values above.
